// File: rtl/eth_rx_stream_reader.sv
// eth_rx_stream_reader: iob_eth register-bus master that drains one frame to a byte stream.
// Define ETH_RX_TIMEOUT_EN to add the poll timeout and its timeout pulse port.
`ifndef ETH_ADDR_W
`define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
`define ETH_STATUS 0
`endif
`ifndef ETH_RCVACK
`define ETH_RCVACK 4
`endif
`ifndef ETH_RX_NBYTES
`define ETH_RX_NBYTES 8
`endif
`ifndef ETH_DATA
`define ETH_DATA 2048
`endif

module eth_rx_stream_reader #(
  parameter int ETH_ADDR_W = `ETH_ADDR_W,
  parameter int NBYTES     = 238,
  parameter int HDR_OFFSET = 14,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  m_valid,
  output logic [7:0]            m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  eth_sel,
  output logic                  eth_we,
  output logic [ETH_ADDR_W-1:0] eth_addr,
  output logic [31:0]           eth_data_in,
  input  logic [31:0]           eth_data_out,
  input  logic                  eth_ready
`ifdef ETH_RX_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam int CW = $clog2(NBYTES + 1);

  localparam logic [ETH_ADDR_W-1:0] A_NB =
    ETH_ADDR_W'(`ETH_RX_NBYTES);
  localparam logic [ETH_ADDR_W-1:0] A_ST =
    ETH_ADDR_W'(`ETH_STATUS);
  localparam logic [ETH_ADDR_W-1:0] A_ACK =
    ETH_ADDR_W'(`ETH_RCVACK);
  localparam logic [ETH_ADDR_W-1:0] A_RD0 =
    ETH_ADDR_W'(`ETH_DATA + HDR_OFFSET);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > 1500 || TIMEOUT < 1) begin : g_bad_cfg
    $error("eth_rx_stream_reader: illegal NBYTES or TIMEOUT");
  end

  typedef enum logic [2:0] {
    IDLE, CFG, POLL, RD, OUT, ACK, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          xfer_end;
  logic          unused_rd_bits;

  // eth_ready only counts while our own select is up
  assign xfer_end       = eth_sel & eth_ready;
  assign unused_rd_bits = ^eth_data_out[31:8];

`ifdef ETH_RX_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT + 1);
  logic [PW-1:0] pcnt;
  logic          pexp;
  assign pexp = (pcnt >= PW'(TIMEOUT));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      eth_sel     <= 1'b0;
      eth_we      <= 1'b0;
      eth_addr    <= '0;
      eth_data_in <= '0;
`ifdef ETH_RX_TIMEOUT_EN
      pcnt        <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef ETH_RX_TIMEOUT_EN
      timeout <= 1'b0;
      if (state == POLL && !pexp)
        pcnt <= pcnt + 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            busy  <= 1'b1;
            state <= CFG;
          end
        end
        CFG: begin
          if (xfer_end) begin
            eth_sel <= 1'b0;
            eth_we  <= 1'b0;
            state   <= POLL;
`ifdef ETH_RX_TIMEOUT_EN
            pcnt    <= '0;
`endif
          end else if (!eth_sel) begin
            eth_sel     <= 1'b1;
            eth_we      <= 1'b1;
            eth_addr    <= A_NB;
            eth_data_in <= 32'(NBYTES);
          end
        end
        POLL: begin
          if (xfer_end) begin
            eth_sel <= 1'b0;
            if (eth_data_out[1]) begin
              cnt   <= '0;
              state <= RD;
            end
`ifdef ETH_RX_TIMEOUT_EN
          end else if (!eth_sel && pexp) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
`endif
          end else if (!eth_sel) begin
            eth_sel  <= 1'b1;
            eth_we   <= 1'b0;
            eth_addr <= A_ST;
          end
        end
        RD: begin
          if (xfer_end) begin
            eth_sel <= 1'b0;
            m_data  <= eth_data_out[7:0];
            m_valid <= 1'b1;
            m_last  <= (cnt == LAST);
            state   <= OUT;
          end else if (!eth_sel) begin
            eth_sel  <= 1'b1;
            eth_we   <= 1'b0;
            eth_addr <= A_RD0 + ETH_ADDR_W'(cnt);
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (cnt == LAST) begin
              state <= ACK;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= RD;
            end
          end
        end
        ACK: begin
          if (xfer_end) begin
            eth_sel <= 1'b0;
            eth_we  <= 1'b0;
            state   <= DONE;
          end else if (!eth_sel) begin
            eth_sel     <= 1'b1;
            eth_we      <= 1'b1;
            eth_addr    <= A_ACK;
            eth_data_in <= 32'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_stream_reader.sv
// Scoreboard bench for eth_rx_stream_reader: behavioural iob_eth model plus stream monitor.
// Build with ETH_RX_TIMEOUT_EN defined to exercise the poll timeout.
`timescale 1ns/1ps
`ifndef ETH_ADDR_W
`define ETH_ADDR_W 12
`endif
`ifndef ETH_STATUS
`define ETH_STATUS 0
`endif
`ifndef ETH_RCVACK
`define ETH_RCVACK 4
`endif
`ifndef ETH_RX_NBYTES
`define ETH_RX_NBYTES 8
`endif
`ifndef ETH_DATA
`define ETH_DATA 2048
`endif

module tb_eth_rx_stream_reader;
  localparam int AW  = `ETH_ADDR_W;
  localparam int NB  = 238;
  localparam int HDR = 14;
  localparam int TO  = 5000;
  localparam int MEMSZ = 1 << AW;
  localparam logic [AW-1:0] A_NB  = AW'(`ETH_RX_NBYTES);
  localparam logic [AW-1:0] A_ST  = AW'(`ETH_STATUS);
  localparam logic [AW-1:0] A_ACK = AW'(`ETH_RCVACK);
  localparam int RD0 = `ETH_DATA + HDR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, m_valid, m_last;
  logic [7:0]    m_data;
  logic          m_ready;
  logic          eth_sel, eth_we, eth_ready;
  logic [AW-1:0] eth_addr;
  logic [31:0]   eth_data_in, eth_data_out;
`ifdef ETH_RX_TIMEOUT_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  eth_rx_stream_reader #(
    .ETH_ADDR_W(AW),
    .NBYTES(NB),
    .HDR_OFFSET(HDR)
`ifdef ETH_RX_TIMEOUT_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .eth_sel(eth_sel),
    .eth_we(eth_we),
    .eth_addr(eth_addr),
    .eth_data_in(eth_data_in),
    .eth_data_out(eth_data_out),
    .eth_ready(eth_ready)
`ifdef ETH_RX_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // behavioural iob_eth state
  logic [7:0]  mem [MEMSZ];
  bit          frame_rdy = 0;
  int          cfg_wr, ack_wr, st_rd, data_rd, bad_txn;
  logic [31:0] cfg_data, ack_data;
  bit          first_cap = 1;
  logic        first_we;
  logic [AW-1:0] first_addr;
  logic [31:0] first_data;

  logic [8:0]  exp_q[$];
  int          rx_cnt, done_cnt, to_cnt;
  int          rdy_pct = 100;

  task automatic serve();
    logic [31:0] w;
    w = $urandom;
    if (!first_cap) begin
      first_cap  = 1;
      first_we   = eth_we;
      first_addr = eth_addr;
      first_data = eth_data_in;
    end
    if (eth_we) begin
      if (eth_addr == A_NB) begin
        cfg_wr++;
        cfg_data = eth_data_in;
      end else if (eth_addr == A_ACK) begin
        ack_wr++;
        ack_data = eth_data_in;
        frame_rdy = 0;
      end else bad_txn++;
    end else if (eth_addr == A_ST) begin
      st_rd++;
      w[1] = frame_rdy;
    end else begin
      data_rd++;
      chk("no_read_while_valid", m_valid, 0);
      w[7:0] = mem[eth_addr];
    end
    eth_data_out = w;
  endtask

  initial begin
    int lat;
    bit real_end;
    lat = 0;
    real_end = 0;
    eth_ready = 0;
    eth_data_out = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        eth_ready = 0;
        lat = 0;
        real_end = 0;
        continue;
      end
      if (real_end) chk("bus_gap", eth_sel, 0);
      real_end = 0;
      if (eth_ready) eth_ready = 0;
      else if (eth_sel) begin
        if (lat == 0) lat = $urandom_range(1, 3);
        lat--;
        if (lat == 0) begin
          eth_ready = 1;
          real_end = 1;
          serve();
        end
      end else if ($urandom_range(0, 9) == 0) begin
        eth_ready = 1;  // stray ready while deselected
        eth_data_out = 32'hffff_ffff;
      end
    end
  end

  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // stream monitor and scoreboard
  initial begin
    bit hold;
    logic [7:0] hd;
    logic hl;
    logic [8:0] e;
    hold = 0;
    hd = 0;
    hl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        continue;
      end
      if (done) done_cnt++;
`ifdef ETH_RX_TIMEOUT_EN
      if (timeout) to_cnt++;
`endif
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hd);
        chk("hold_last", m_last, hl);
      end
      hold = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", m_data, e[7:0]);
          chk("byte_last", m_last, e[8]);
        end
        rx_cnt++;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_start(bit clr);
    @(posedge clk);
    #1;
    if (clr) first_cap = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic load_frame(bit hello);
    string s;
    logic [7:0] b;
    s = "Hello from PC!";
    mem[RD0-1] = 8'($urandom);
    mem[RD0+NB] = 8'($urandom);
    for (int i = 0; i < NB; i++) begin
      if (hello) b = (i < s.len()) ? 8'(s[i]) : 8'h00;
      else b = 8'($urandom);
      mem[RD0+i] = b;
      exp_q.push_back({(i == NB - 1), b});
    end
    frame_rdy = 1;
  endtask

  task automatic clr_stats();
    cfg_wr = 0;
    ack_wr = 0;
    st_rd = 0;
    data_rd = 0;
    done_cnt = 0;
    rx_cnt = 0;
    to_cnt = 0;
    cfg_data = 0;
    ack_data = 0;
  endtask

  task automatic wait_cfg();
    for (int i = 0; i < 200 && cfg_wr == 0; i++) @(posedge clk);
  endtask

  task automatic run_frame(bit hello, int pct, bit start_on_done);
    bit seen;
    clr_stats();
    rdy_pct = pct;
    pulse_start(1);
    chk("busy_after_start", busy, 1);
    wait_cfg();
    cyc($urandom_range(20, 40));
    pulse_start(0);
    load_frame(hello);
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
    if (start_on_done && seen) begin
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (eth_sel || busy) seen = 1;
      end
      chk("start_with_done_ignored", seen, 0);
    end
    cyc(3);
    chk("first_txn_we", first_we, 1);
    chk("first_txn_addr", first_addr, A_NB);
    chk("first_txn_data", first_data, NB);
    chk("cfg_writes", cfg_wr, 1);
    chk("cfg_data", cfg_data, NB);
    chk("poll_repeats", st_rd >= 2, 1);
    chk("data_reads", data_rd, NB);
    chk("ack_writes", ack_wr, 1);
    chk("ack_data", ack_data, 1);
    chk("done_pulses", done_cnt, 1);
    chk("bytes_rx", rx_cnt, NB);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    chk("bad_txn", bad_txn, 0);
  endtask

  initial begin
    bit seen;
    int n;
    bad_txn = 0;
    clr_stats();
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);

    cyc(10);
    @(negedge clk);
    rst = 0;
    cyc(2);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_sel", eth_sel, 0);
    chk("rst_we", eth_we, 0);
    chk("rst_addr", eth_addr, 0);
    chk("rst_wdata", eth_data_in, 0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (eth_sel) seen = 1;
    end
    chk("idle_no_sel", seen, 0);

    run_frame(1, 100, 0);
    run_frame(0, 30, 1);

    clr_stats();
    rdy_pct = 70;
    pulse_start(1);
    wait_cfg();
    cyc(5);
    load_frame(0);
    for (int i = 0; i < 5000 && rx_cnt < 101; i++) @(posedge clk);
    chk("midframe_progress", rx_cnt >= 101, 1);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("mid_rst_sel", eth_sel, 0);
    chk("mid_rst_we", eth_we, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", m_data, 0);
    frame_rdy = 0;
    exp_q.delete();
    cyc(3);
    @(negedge clk);
    rst = 0;
    run_frame(0, 50, 0);

`ifdef ETH_RX_TIMEOUT_EN
    clr_stats();
    rdy_pct = 100;
    pulse_start(1);
    wait_cfg();
    n = 0;
    while (n < 6000 && to_cnt == 0) begin
      @(posedge clk);
      n++;
    end
    chk("timeout_latency_ok", (n >= 4990 && n <= 5030), 1);
    cyc(5);
    chk("timeout_pulses", to_cnt, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_done", done_cnt, 0);
    chk("timeout_no_ack", ack_wr, 0);
    chk("timeout_sel", eth_sel, 0);
`else
    n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
